// File: rtl/seven_seg_pkg.sv
// Shared glyph constants and hex decode for the seven-segment scan controller.
// Glyphs are active-low, bit order g..a (bit 6 = g, bit 0 = a).
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        PH_BLANK,
        PH_ON
    } phase_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_decode.sv
// Nibble to active-low segment decoder with a blank override.
// Ports: nibble (hex digit), blank (force all segments off), seg (g..a, active-low).
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : hex_to_seg(nibble);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller with tear-free
// frame-boundary update, inter-digit blanking and leading-zero blanking.
// Ports: CLK, RESET (async, active-high), ENABLE (clock enable), LOAD strobe with
// VALUE/DP_IN/MASK/LZB; outputs SS_AN, SS_SEG, SS_DP (active-low), FRAME_START.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ENABLE,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic [DIGITS-1:0]     DP_IN,
    input  logic [DIGITS-1:0]     MASK,
    input  logic                  LZB,
    output logic [DIGITS-1:0]     SS_AN,
    output logic [6:0]            SS_SEG,
    output logic                  SS_DP,
    output logic                  FRAME_START
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int IW = $clog2(DIGITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;

    logic [4*DIGITS-1:0]   pend_value;
    logic [DIGITS-1:0]     pend_dp;
    logic [DIGITS-1:0]     pend_mask;
    logic                  pend_lzb;

    logic [4*DIGITS-1:0]   disp_value;
    logic [DIGITS-1:0]     disp_dp;
    logic [DIGITS-1:0]     disp_mask;
    logic                  disp_lzb;

    logic                  slot_end;
    logic                  frame_end;
    phase_t                phase;

    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_mask;
    logic                  upper_nz;
    logic                  lz_blank;
    logic                  digit_blank;
    logic [6:0]            seg_next;
    logic [DIGITS-1:0]     an_next;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign phase     = (cnt < CNT_BLANK) ? PH_BLANK : PH_ON;

    // Select the current digit and look for any nonzero nibble at or above it.
    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_mask = 1'b0;
        upper_nz = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (idx == IW'(j)) begin
                cur_nib  = disp_value[4*j +: 4];
                cur_dp   = disp_dp[j];
                cur_mask = disp_mask[j];
            end
            if (j >= int'(idx) && disp_value[4*j +: 4] != 4'h0) begin
                upper_nz = 1'b1;
            end
        end
    end

    // Digit 0 is never zero-blanked; a lit DP keeps its digit visible.
    assign lz_blank    = disp_lzb && (idx != '0) && !upper_nz && !cur_dp;
    assign digit_blank = !cur_mask || lz_blank;

    seven_seg_decode u_decode (
        .nibble (cur_nib),
        .blank  (digit_blank),
        .seg    (seg_next)
    );

    always_comb begin
        an_next = '1;
        if (phase == PH_ON && !digit_blank) begin
            an_next[idx] = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt         <= '0;
            idx         <= '0;
            pend_value  <= '0;
            pend_dp     <= '0;
            pend_mask   <= '0;
            pend_lzb    <= 1'b0;
            disp_value  <= '0;
            disp_dp     <= '0;
            disp_mask   <= '0;
            disp_lzb    <= 1'b0;
            SS_AN       <= '1;
            SS_SEG      <= SEG_BLANK;
            SS_DP       <= 1'b1;
            FRAME_START <= 1'b0;
        end else if (ENABLE) begin
            cnt <= slot_end ? '0 : cnt + CW'(1);
            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
            if (LOAD) begin
                pend_value <= VALUE;
                pend_dp    <= DP_IN;
                pend_mask  <= MASK;
                pend_lzb   <= LZB;
            end
            // A LOAD coinciding with the boundary bypasses the pending copy.
            if (frame_end) begin
                disp_value <= LOAD ? VALUE : pend_value;
                disp_dp    <= LOAD ? DP_IN : pend_dp;
                disp_mask  <= LOAD ? MASK  : pend_mask;
                disp_lzb   <= LOAD ? LZB   : pend_lzb;
            end
            SS_AN       <= an_next;
            SS_SEG      <= seg_next;
            SS_DP       <= digit_blank || !cur_dp;
            FRAME_START <= (cnt == '0) && (idx == '0);
        end
    end

endmodule
